// File: rtl/fetch_pc_stage_if.sv
// Fetch-stage bundle: redirect/stall control in, instruction-memory port, IF/ID output to decode.
// master = fetch stage side, slave = the surrounding core (branch unit, memory, decode).
interface fetch_pc_stage_if #(
  parameter int PC_W  = 9,
  parameter int INS_W = 32
);
  logic             PcSel;
  logic [31:0]      BrPC;
  logic             Stall;
  logic [PC_W-1:0]  imem_addr;
  logic [INS_W-1:0] imem_rdata;
  logic [PC_W-1:0]  id_pc;
  logic [INS_W-1:0] id_instr;
  logic             id_valid;

  modport master (
    input  PcSel, BrPC, Stall, imem_rdata,
    output imem_addr, id_pc, id_instr, id_valid
  );

  modport slave (
    output PcSel, BrPC, Stall, imem_rdata,
    input  imem_addr, id_pc, id_instr, id_valid
  );
endinterface

// File: rtl/fetch_pc_stage.sv
// PC register + two-deep fetch pipe (F1 drives the address, F2 takes the data) into IF/ID; 2 cycles PC->IF/ID.
// Stall freezes PC/F2/IF-ID with a one-entry hold for the read in flight; PcSel flushes everything.
module fetch_pc_stage #(
  parameter int              PC_W     = 9,
  parameter int              INS_W    = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  fetch_pc_stage_if.master  bus
);

  typedef struct packed {
    logic [PC_W-1:0] pc;
    logic            vld;
  } f2_t;

  typedef struct packed {
    logic [PC_W-1:0]  pc;
    logic [INS_W-1:0] instr;
    logic             vld;
  } id_t;

  logic [PC_W-1:0]  pc_q, pc_d;
  f2_t              f2_q, f2_d;
  id_t              id_q, id_d;
  logic [INS_W-1:0] hold_q, hold_d;
  logic             hold_vld_q, hold_vld_d;
  logic [INS_W-1:0] f2_dat;
  logic [PC_W-1:0]  redirect_pc;
  logic             unused_br_bits;

  // Only the in-range, word-aligned part of the redirect target matters.
  assign redirect_pc    = {bus.BrPC[PC_W-1:2], 2'b00};
  assign unused_br_bits = ^{bus.BrPC[31:PC_W], bus.BrPC[1:0]};

  // Once a stall has parked F2's word in the hold entry, the memory output belongs to F1.
  assign f2_dat = hold_vld_q ? hold_q : bus.imem_rdata;

  always_comb begin
    pc_d       = pc_q;
    f2_d       = f2_q;
    id_d       = id_q;
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    if (bus.PcSel) begin
      pc_d       = redirect_pc;
      f2_d.vld   = 1'b0;
      id_d.vld   = 1'b0;
      hold_vld_d = 1'b0;
    end else if (bus.Stall) begin
      if (f2_q.vld && !hold_vld_q) begin
        hold_d     = bus.imem_rdata;
        hold_vld_d = 1'b1;
      end
    end else begin
      pc_d       = pc_q + PC_W'(4);
      f2_d       = '{pc: pc_q, vld: 1'b1};
      id_d       = '{pc: f2_q.pc, instr: f2_dat, vld: f2_q.vld};
      hold_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      f2_q       <= '0;
      id_q       <= '0;
      hold_q     <= '0;
      hold_vld_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      f2_q       <= f2_d;
      id_q       <= id_d;
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.id_pc     = id_q.pc;
  assign bus.id_instr  = id_q.instr;
  assign bus.id_valid  = id_q.vld;

endmodule
